// File: rtl/calc_unit_if.sv
// calc_unit_if: operand, control and result bundle of the execute stage.
// The control FSM / datapath side is master; calc_unit is slave.
interface calc_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic [WIDTH-1:0] in_PC;
  logic [WIDTH-1:0] in_imm;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic             PCSrc;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUOut;
  logic [WIDTH-1:0] ALUMuxOut;
  logic [WIDTH-1:0] B_sr;
  logic             Zero;
  logic             Negative;

  modport master (
    output in_A, in_B, in_PC, in_imm, ALUSrcA, ALUSrcB, ALUOp, PCSrc, start,
    input  busy, done, ALUOut, ALUMuxOut, B_sr, Zero, Negative
  );

  modport slave (
    input  in_A, in_B, in_PC, in_imm, ALUSrcA, ALUSrcB, ALUOp, PCSrc, start,
    output busy, done, ALUOut, ALUMuxOut, B_sr, Zero, Negative
  );
endinterface

// File: rtl/calc_unit.sv
// calc_unit: multi-cycle datapath execute stage. Operand registers, ALUSrcA/B
// muxes, ALU, ALUOut register with Zero/Negative flags, PCSrc result mux and a
// start/busy/done handshake.
// Build option: CALC_FAST_SHIFT_EN selects a single-cycle barrel shifter;
// without it, sll/srl shift one bit per cycle in the SHIFT state.
module calc_unit #(
  parameter int WIDTH = 16,
  parameter int INC   = 2
) (
  input logic        CLK,
  input logic        Reset_n,
  calc_unit_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;   // 1: shift right (srl)

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic             launch_shift;

  // Operand source muxes
  always_comb begin
    case (bus.ALUSrcA)
      2'd0:    op_a = bus.in_PC;
      2'd1:    op_a = WIDTH'(INC);
      2'd2:    op_a = a_sr_q;
      default: op_a = '0;
    endcase
    case (bus.ALUSrcB)
      2'd0:    op_b = b_sr_q;
      2'd1:    op_b = WIDTH'(INC);
      2'd2:    op_b = bus.in_imm;
      default: op_b = '0;
    endcase
  end

  assign shamt    = op_b[SW-1:0];
  assign is_shift = bus.ALUOp[2] & bus.ALUOp[1];

`ifdef CALC_FAST_SHIFT_EN
  assign launch_shift = 1'b0;
`else
  // A zero-length shift finishes in one cycle like any other op.
  assign launch_shift = is_shift && (shamt != '0);
`endif

  // Combinational ALU
  always_comb begin
    alu_res = '0;
    case (bus.ALUOp)
      3'd0: alu_res = op_a + op_b;
      3'd1: alu_res = op_a - op_b;
      3'd2: alu_res = op_a & op_b;
      3'd3: alu_res = op_a | op_b;
      3'd4: alu_res = op_a ^ op_b;
      3'd5: alu_res[0] = $signed(op_a) < $signed(op_b);
`ifdef CALC_FAST_SHIFT_EN
      3'd6: alu_res = op_a << shamt;
      3'd7: alu_res = op_a >> shamt;
`else
      3'd6: alu_res = op_a;
      3'd7: alu_res = op_a;
`endif
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start && launch_shift) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == SW'(1))           state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and handshake outputs
  always_comb begin
    a_sr_d    = busy_q ? a_sr_q : bus.in_A;
    b_sr_d    = busy_q ? b_sr_q : bus.in_B;
    alu_out_d = alu_out_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    work_d    = work_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    busy_d    = (state_d == ST_SHIFT);
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (launch_shift) begin
            work_d = op_a;
            cnt_d  = shamt;
            dir_d  = bus.ALUOp[0];
          end else begin
            alu_out_d = alu_res;
            done_d    = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        work_d = dir_q ? (work_q >> 1) : (work_q << 1);
        cnt_d  = cnt_q - SW'(1);
        // Final step writes the just-shifted value straight into ALUOut.
        if (cnt_q == SW'(1)) begin
          alu_out_d = work_d;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
    if (done_d) begin
      zero_d = (alu_out_d == '0);
      neg_d  = alu_out_d[WIDTH-1];
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      alu_out_q <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ALUOut    = alu_out_q;
  assign bus.B_sr      = b_sr_q;
  assign bus.Zero      = zero_q;
  assign bus.Negative  = neg_q;
  assign bus.ALUMuxOut = bus.PCSrc ? alu_out_q : alu_res;

endmodule

// File: tb/tb_calc_unit.sv
// tb_calc_unit: directed and randomized checks of calc_unit against a
// cycle-count reference model. Honors CALC_FAST_SHIFT_EN like the design.
module tb_calc_unit;

  localparam int W  = 16;
  localparam int SW = 4;
`ifdef CALC_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_unit_if #(.WIDTH(W)) bus ();

  calc_unit #(.WIDTH(W), .INC(2)) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [W-1:0] m_asr = '0, m_bsr = '0, m_out = '0, m_pend = '0;
  logic         m_zero = 1'b0, m_neg = 1'b0, m_done = 1'b0;
  int           m_rem = 0;   // cycles left until a pending shift completes

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input bit do_shift);
    int amt;
    amt = int'(b % W);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      3'd6: return do_shift ? W'(a * (2 ** amt)) : a;
      default: return do_shift ? W'(a / (2 ** amt)) : a;
    endcase
  endfunction

  function automatic logic [W-1:0] src_a();
    case (bus.ALUSrcA)
      2'd0: return bus.in_PC;
      2'd1: return W'(2);
      2'd2: return m_asr;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] src_b();
    case (bus.ALUSrcB)
      2'd0: return m_bsr;
      2'd1: return W'(2);
      2'd2: return bus.in_imm;
      default: return '0;
    endcase
  endfunction

  // One clock: check combinational path, advance model at the edge, check registers.
  task automatic tick();
    logic [W-1:0] a, b, r;
    int  amt;
    bit  was_busy;
    #1;
    a = src_a();
    b = src_b();
    r = ref_alu(bus.ALUOp, a, b, FAST);
    check("alumuxout", bus.ALUMuxOut, bus.PCSrc ? m_out : r);
    @(posedge clk);
    was_busy = (m_rem > 0);
    m_done = 1'b0;
    if (!rst_n) begin
      m_asr = '0; m_bsr = '0; m_out = '0; m_zero = 1'b0; m_neg = 1'b0; m_rem = 0;
    end else begin
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_out  = m_pend;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        amt = int'(b % W);
        if (!FAST && bus.ALUOp >= 3'd6 && amt > 0) begin
          m_rem  = amt;
          m_pend = ref_alu(bus.ALUOp, a, b, 1'b1);
        end else begin
          m_out  = ref_alu(bus.ALUOp, a, b, 1'b1);
          m_done = 1'b1;
        end
      end
      if (m_done) begin
        m_zero = (m_out == 0);
        m_neg  = m_out[W-1];
      end
      if (!was_busy) begin
        m_asr = bus.in_A;
        m_bsr = bus.in_B;
      end
    end
    #1;
    check("aluout", bus.ALUOut, m_out);
    check("zero", W'(bus.Zero), W'(m_zero));
    check("negative", W'(bus.Negative), W'(m_neg));
    check("busy", W'(bus.busy), W'(m_rem > 0));
    check("done", W'(bus.done), W'(m_done));
    check("b_sr", bus.B_sr, m_bsr);
  endtask

  task automatic set_op(input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] op,
                        input logic st);
    bus.ALUSrcA = sa;
    bus.ALUSrcB = sb;
    bus.ALUOp   = op;
    bus.start   = st;
  endtask

  task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_A = a;
    bus.in_B = b;
    set_op(2'd0, 2'd0, 3'd0, 1'b0);
    tick();
  endtask

  int busy_cycles;

  initial begin
    bus.in_A = '0; bus.in_B = '0; bus.in_PC = '0; bus.in_imm = '0;
    bus.PCSrc = 1'b0;
    set_op(2'd0, 2'd0, 3'd0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset held with start asserted
    tick();
    tick();
    check("t1_aluout", bus.ALUOut, '0);
    check("t1_busy", W'(bus.busy), '0);
    check("t1_done", W'(bus.done), '0);
    rst_n = 1'b1;

    // 2: PC + INC
    bus.in_PC = 16'h0010;
    set_op(2'd0, 2'd1, 3'd0, 1'b1);
    #1 check("t2_mux_comb", bus.ALUMuxOut, 16'h0012);
    tick();
    check("t2_aluout", bus.ALUOut, 16'h0012);
    check("t2_done", W'(bus.done), W'(1));
    check("t2_zero", W'(bus.Zero), '0);

    // 3: sub to zero, sub negative, signed slt
    load_ab(16'd5, 16'd5);
    set_op(2'd2, 2'd0, 3'd1, 1'b1); tick();
    check("t3_sub_zero", W'(bus.Zero), W'(1));
    load_ab(16'h0001, 16'h0002);
    set_op(2'd2, 2'd0, 3'd1, 1'b1); tick();
    check("t3_sub_neg", bus.ALUOut, 16'hFFFF);
    check("t3_neg_flag", W'(bus.Negative), W'(1));
    load_ab(16'hFFFF, 16'h0001);
    set_op(2'd2, 2'd0, 3'd5, 1'b1); tick();
    check("t3_slt", bus.ALUOut, 16'h0001);
    // back-to-back starts each produce a done
    set_op(2'd1, 2'd1, 3'd0, 1'b1); tick();
    check("t3_b2b_done", W'(bus.done), W'(1));

    // 4: sll 1 by 4, start pulsed and in_A changed mid-shift
    load_ab(16'h0001, 16'h0000);
    bus.in_imm = 16'd4;
    set_op(2'd2, 2'd2, 3'd6, 1'b1);
    busy_cycles = 0;
    tick();
    if (bus.busy) busy_cycles++;
    for (int i = 0; i < 4; i++) begin
      set_op(2'd2, 2'd1, 3'd0, (i == 1));
      bus.in_A = 16'(16'hA5A5 + i);
      tick();
      if (bus.busy) busy_cycles++;
    end
    check("t4_result", bus.ALUOut, 16'h0010);
    bus.start = 1'b0;
    tick();
    check("t4_done_pulse", W'(bus.done), '0);
`ifdef CALC_FAST_SHIFT_EN
    check("t4_busy_cycles", W'(busy_cycles), '0);
`else
    check("t4_busy_cycles", W'(busy_cycles), W'(4));
`endif

    // 5: srl aborted by reset, then zero-length shift
    load_ab(16'h8000, 16'h0000);
    bus.in_imm = 16'd15;
    set_op(2'd2, 2'd2, 3'd7, 1'b1);
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_abort_out", bus.ALUOut, '0);
    check("t5_abort_busy", W'(bus.busy), '0);
    tick();
    check("t5_no_done", W'(bus.done), '0);
    load_ab(16'h1234, 16'h0000);
    bus.in_imm = 16'd0;
    set_op(2'd2, 2'd2, 3'd7, 1'b1); tick();
    check("t5_amt0", bus.ALUOut, 16'h1234);

`ifdef CALC_FAST_SHIFT_EN
    // 6: single-cycle barrel shift
    load_ab(16'h0001, 16'h0000);
    bus.in_imm = 16'd15;
    set_op(2'd2, 2'd2, 3'd6, 1'b1); tick();
    check("t6_fast_sll", bus.ALUOut, 16'h8000);
    check("t6_fast_neg", W'(bus.Negative), W'(1));
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_A    = 16'($urandom);
      bus.in_B    = 16'($urandom);
      bus.in_PC   = 16'($urandom);
      bus.in_imm  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      bus.PCSrc   = 1'($urandom_range(0, 1));
      bus.ALUSrcA = 2'($urandom_range(0, 3));
      bus.ALUSrcB = 2'($urandom_range(0, 3));
      bus.ALUOp   = 3'($urandom_range(0, 7));
      bus.start   = 1'($urandom_range(0, 1));
      rst_n       = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
